// File: rtl/gesture_led_ctrl.sv
// Gesture-driven LED mode controller: menu select, confirm/cancel/lamp-test timed displays.
// Optional macro SEL_TIMEOUT_EN adds an idle-gesture timeout that drops SEL back to IDLE.
module gesture_led_ctrl #(
    parameter logic [31:0] DONE_TIME   = 32'd100_000_000,
    parameter logic [31:0] CANCEL_TIME = 32'd50_000_000,
    parameter logic [31:0] TEST_TIME   = 32'd25_000_000,
    parameter logic [31:0] SEL_TIMEOUT = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gest_vld,
    input  logic [3:0] gest_code,
    output logic [3:0] value,
    output logic       busy,
    output logic       done_pulse
);

    // Handshake: gest_vld is a one-cycle strobe with no back-pressure; a gesture is
    // consumed on the edge it is high or dropped if the current state ignores it.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEL    = 3'd1,
        S_DONE   = 3'd2,
        S_CANCEL = 3'd3,
        S_TEST   = 3'd4
    } state_t;

    localparam logic [3:0] G_NEXT    = 4'd1;
    localparam logic [3:0] G_PREV    = 4'd2;
    localparam logic [3:0] G_CONFIRM = 4'd3;
    localparam logic [3:0] G_CANCEL  = 4'd4;
    localparam logic [3:0] G_TEST    = 4'd5;

    state_t      state, state_next;
    logic [1:0]  item, item_next;
    logic [31:0] cnt, cnt_next;
    logic [3:0]  value_next;
    logic        busy_next;
    logic        done_pulse_next;
    logic        g_next, g_prev, g_confirm, g_cancel, g_test;
    logic        sel_kick;

    assign g_next    = gest_vld && (gest_code == G_NEXT);
    assign g_prev    = gest_vld && (gest_code == G_PREV);
    assign g_confirm = gest_vld && (gest_code == G_CONFIRM);
    assign g_cancel  = gest_vld && (gest_code == G_CANCEL);
    assign g_test    = gest_vld && (gest_code == G_TEST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            item       <= 2'd0;
            cnt        <= 32'd0;
            value      <= 4'd0;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            item       <= item_next;
            cnt        <= cnt_next;
            value      <= value_next;
            busy       <= busy_next;
            done_pulse <= done_pulse_next;
        end
    end

    always_comb begin
        state_next = state;
        item_next  = item;
        sel_kick   = 1'b0;

        case (state)
            S_IDLE: begin
                if (g_next) begin
                    state_next = S_SEL;
                    item_next  = 2'd0;
                end else if (g_prev) begin
                    state_next = S_SEL;
                    item_next  = 2'd3;
                end else if (g_test) begin
                    state_next = S_TEST;
                end
            end
            S_SEL: begin
                // Any navigation gesture takes priority over a coincident timeout.
                if (g_next) begin
                    item_next = item + 2'd1;
                    sel_kick  = 1'b1;
                end else if (g_prev) begin
                    item_next = item - 2'd1;
                    sel_kick  = 1'b1;
                end else if (g_confirm) begin
                    state_next = S_DONE;
                end else if (g_cancel) begin
                    state_next = S_CANCEL;
`ifdef SEL_TIMEOUT_EN
                end else if (cnt == SEL_TIMEOUT - 32'd1) begin
                    state_next = S_IDLE;
`endif
                end
            end
            S_DONE: begin
                if (cnt == DONE_TIME - 32'd1) state_next = S_IDLE;
            end
            S_CANCEL: begin
                if (cnt == CANCEL_TIME - 32'd1) state_next = S_IDLE;
            end
            S_TEST: begin
                if (cnt == TEST_TIME - 32'd1) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // One shared counter: cleared on every state change, running only where time matters.
    always_comb begin
        cnt_next = 32'd0;
        if (state_next == state) begin
            case (state)
                S_DONE, S_CANCEL, S_TEST: cnt_next = cnt + 32'd1;
`ifdef SEL_TIMEOUT_EN
                S_SEL:                    cnt_next = sel_kick ? 32'd0 : cnt + 32'd1;
`endif
                default:                  cnt_next = 32'd0;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register with one cycle of latency.
    always_comb begin
        value_next      = 4'd0;
        busy_next       = 1'b0;
        done_pulse_next = 1'b0;
        case (state_next)
            S_IDLE: value_next = 4'd0;
            S_SEL:  value_next = {2'b00, item_next} + 4'd2;
            S_DONE: begin
                value_next      = 4'd6;
                busy_next       = 1'b1;
                done_pulse_next = (state != S_DONE);
            end
            S_CANCEL: begin
                value_next = 4'd7;
                busy_next  = 1'b1;
            end
            S_TEST: begin
                value_next = 4'd1;
                busy_next  = 1'b1;
            end
            default: value_next = 4'd0;
        endcase
    end

endmodule

// File: tb/tb_gesture_led_ctrl.sv
// Directed self-checking bench for gesture_led_ctrl; honours SEL_TIMEOUT_EN when defined.
module tb_gesture_led_ctrl;

    logic       clk;
    logic       rst_n;
    logic       gest_vld;
    logic [3:0] gest_code;
    logic [3:0] value;
    logic       busy;
    logic       done_pulse;

    int checks = 0;
    int errors = 0;

    gesture_led_ctrl #(
        .DONE_TIME  (32'd8),
        .CANCEL_TIME(32'd6),
        .TEST_TIME  (32'd4),
        .SEL_TIMEOUT(32'd10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gest_vld  (gest_vld),
        .gest_code (gest_code),
        .value     (value),
        .busy      (busy),
        .done_pulse(done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] code);
        @(negedge clk);
        gest_vld  = 1'b1;
        gest_code = code;
        @(posedge clk);
        #1;
        gest_vld  = 1'b0;
        gest_code = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        logic [5:0] exp_v;
        rst_n     = 1'b1;
        gest_vld  = 1'b0;
        gest_code = 4'd0;
        #3 rst_n  = 1'b0;
        tick();
        tick();
        exp_v = {4'd0, 1'b0, 1'b0};
        checks++;
        if ({value, busy, done_pulse} !== exp_v) begin
            errors++;
            $display("FAIL reset_state: got v/b/d=%b exp %b", {value, busy, done_pulse}, exp_v);
        end
        // gesture presented together with release must be taken on the very next edge
        @(negedge clk);
        rst_n     = 1'b1;
        gest_vld  = 1'b1;
        gest_code = 4'd1;
        @(posedge clk);
        #1;
        gest_vld  = 1'b0;
        gest_code = 4'd0;
        exp_v = {4'd2, 1'b0, 1'b0};
        checks++;
        if ({value, busy, done_pulse} !== exp_v) begin
            errors++;
            $display("FAIL first_edge_after_reset: got v/b/d=%b exp %b", {value, busy, done_pulse}, exp_v);
        end
    endtask

    task automatic test_nav();
        logic [3:0] exp_seq [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd2, 4'd5};
        logic [3:0] codes   [6] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(codes[i]);
            checks++;
            if (value !== exp_seq[i] || busy !== 1'b0 || done_pulse !== 1'b0) begin
                errors++;
                $display("FAIL nav_step%0d: got value=%0d busy=%b dp=%b exp value=%0d busy=0 dp=0",
                         i, value, busy, done_pulse, exp_seq[i]);
            end
        end
        // lamp test and junk codes are ignored while selecting
        send(4'd5);
        send(4'd0);
        checks++;
        if (value !== 4'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL nav_ignore_test: got value=%0d busy=%b exp value=5 busy=0", value, busy);
        end
    endtask

    task automatic test_done();
        logic [5:0] exp_v;
        do_reset();
        send(4'd1);
        send(4'd3);
        exp_v = {4'd6, 1'b1, 1'b1};
        checks++;
        if ({value, busy, done_pulse} !== exp_v) begin
            errors++;
            $display("FAIL done_entry: got v/b/d=%b exp %b", {value, busy, done_pulse}, exp_v);
        end
        for (int i = 1; i < 8; i++) begin
            if (i == 3) send(4'd1);
            else tick();
            exp_v = {4'd6, 1'b1, 1'b0};
            checks++;
            if ({value, busy, done_pulse} !== exp_v) begin
                errors++;
                $display("FAIL done_hold%0d: got v/b/d=%b exp %b", i, {value, busy, done_pulse}, exp_v);
            end
        end
        tick();
        exp_v = {4'd0, 1'b0, 1'b0};
        checks++;
        if ({value, busy, done_pulse} !== exp_v) begin
            errors++;
            $display("FAIL done_exit: got v/b/d=%b exp %b", {value, busy, done_pulse}, exp_v);
        end
        send(4'd1);
        checks++;
        if (value !== 4'd2) begin
            errors++;
            $display("FAIL done_item_reload: got value=%0d exp 2", value);
        end
    endtask

    task automatic test_cancel();
        logic [5:0] exp_v;
        do_reset();
        send(4'd1);
        send(4'd4);
        exp_v = {4'd7, 1'b1, 1'b0};
        checks++;
        if ({value, busy, done_pulse} !== exp_v) begin
            errors++;
            $display("FAIL cancel_entry: got v/b/d=%b exp %b", {value, busy, done_pulse}, exp_v);
        end
        for (int i = 1; i < 6; i++) begin
            if (i == 1) send(4'd1);
            else tick();
            checks++;
            if ({value, busy, done_pulse} !== exp_v) begin
                errors++;
                $display("FAIL cancel_hold%0d: got v/b/d=%b exp %b", i, {value, busy, done_pulse}, exp_v);
            end
        end
        tick();
        exp_v = {4'd0, 1'b0, 1'b0};
        checks++;
        if ({value, busy, done_pulse} !== exp_v) begin
            errors++;
            $display("FAIL cancel_exit: got v/b/d=%b exp %b", {value, busy, done_pulse}, exp_v);
        end
        tick();
        checks++;
        if ({value, busy, done_pulse} !== exp_v) begin
            errors++;
            $display("FAIL cancel_not_queued: got v/b/d=%b exp %b", {value, busy, done_pulse}, exp_v);
        end
    endtask

    task automatic test_lamp();
        do_reset();
        send(4'd9);
        send(4'd3);
        send(4'd4);
        checks++;
        if (value !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got value=%0d busy=%b exp value=0 busy=0", value, busy);
        end
        send(4'd5);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (value !== 4'd1 || busy !== 1'b1 || done_pulse !== 1'b0) begin
                errors++;
                $display("FAIL lamp_hold%0d: got value=%0d busy=%b dp=%b exp value=1 busy=1 dp=0",
                         i, value, busy, done_pulse);
            end
            tick();
        end
        checks++;
        if (value !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL lamp_exit: got value=%0d busy=%b exp value=0 busy=0", value, busy);
        end
    endtask

    task automatic test_sel_timeout();
        do_reset();
        send(4'd1);
`ifdef SEL_TIMEOUT_EN
        for (int i = 1; i < 10; i++) begin
            if (i == 4) send(4'd5);
            else tick();
        end
        checks++;
        if (value !== 4'd2) begin
            errors++;
            $display("FAIL timeout_hold: got value=%0d exp 2", value);
        end
        tick();
        checks++;
        if (value !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_exit: got value=%0d busy=%b exp value=0 busy=0", value, busy);
        end
        send(4'd1);
        for (int i = 1; i < 10; i++) tick();
        send(4'd1);
        checks++;
        if (value !== 4'd3) begin
            errors++;
            $display("FAIL timeout_gesture_wins: got value=%0d exp 3", value);
        end
        for (int i = 1; i < 10; i++) tick();
        checks++;
        if (value !== 4'd3) begin
            errors++;
            $display("FAIL timeout_restart_hold: got value=%0d exp 3", value);
        end
        tick();
        checks++;
        if (value !== 4'd0) begin
            errors++;
            $display("FAIL timeout_restart_exit: got value=%0d exp 0", value);
        end
`else
        for (int i = 0; i < 25; i++) tick();
        checks++;
        if (value !== 4'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout_hold: got value=%0d busy=%b exp value=2 busy=0", value, busy);
        end
        send(4'd4);
        checks++;
        if (value !== 4'd7 || busy !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout_cancel: got value=%0d busy=%b exp value=7 busy=1", value, busy);
        end
`endif
    endtask

    task automatic test_reset_mid_done();
        logic [5:0] exp_v;
        do_reset();
        send(4'd1);
        send(4'd3);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        exp_v = {4'd0, 1'b0, 1'b0};
        checks++;
        if ({value, busy, done_pulse} !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_done: got v/b/d=%b exp %b", {value, busy, done_pulse}, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({value, busy, done_pulse} !== exp_v) begin
            errors++;
            $display("FAIL reset_no_pending: got v/b/d=%b exp %b", {value, busy, done_pulse}, exp_v);
        end
        send(4'd2);
        exp_v = {4'd5, 1'b0, 1'b0};
        checks++;
        if ({value, busy, done_pulse} !== exp_v) begin
            errors++;
            $display("FAIL reset_then_prev: got v/b/d=%b exp %b", {value, busy, done_pulse}, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_nav();
        test_done();
        test_cancel();
        test_lamp();
        test_sel_timeout();
        test_reset_mid_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gesture_led_ctrl.md
GESTURE_LED_CTRL -- requirements
Module: gesture_led_ctrl

Interface
REQ-001 Parameter DONE_TIME, default 32'd100_000_000: DONE state duration in clk cycles (2 s at 50 MHz).
REQ-002 Parameter CANCEL_TIME, default 32'd50_000_000: CANCEL state duration in cycles.
REQ-003 Parameter TEST_TIME, default 32'd25_000_000: TEST state duration in cycles.
REQ-004 Parameter SEL_TIMEOUT, default 32'd500_000_000: idle-gesture timeout in SEL, in cycles.
REQ-005 clk  input  1  system clock; the block uses only this one clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 gest_vld  input  1  one-cycle strobe; gest_code is valid while it is high.
REQ-008 gest_code  input  4  gesture: 1=next, 2=prev, 3=confirm, 4=cancel, 5=lamp test; all other codes are ignored.
REQ-009 value  output  4  LED display mode for the downstream LED driver (0 off, 1 all on, 2..5 single LED, 6 running, 7 flash); registered.
REQ-010 busy  output  1  high while in DONE, CANCEL or TEST; registered.
REQ-011 done_pulse  output  1  one-cycle high pulse on entry to DONE (beeper trigger); registered.

Function
REQ-012 The FSM SHALL have exactly five states: IDLE, SEL, DONE, CANCEL, TEST.
REQ-013 A gesture SHALL be accepted on the rising clk edge where gest_vld=1; value/busy/done_pulse SHALL reflect it in the cycle after that edge (latency 1).
REQ-014 IDLE: value=0; next -> SEL with item=0; prev -> SEL with item=3; test -> TEST; confirm/cancel/invalid codes SHALL be ignored.
REQ-015 SEL: value=2+item (item is 2 bits); next: item+1, wrapping 3->0; prev: item-1, wrapping 0->3; confirm -> DONE; cancel -> CANCEL; test is ignored.
REQ-016 In SEL, each accepted next/prev SHALL clear the timeout counter; ignored codes SHALL NOT clear it.
REQ-017 DONE: value=6 for exactly DONE_TIME cycles, then IDLE; CANCEL: value=7 for exactly CANCEL_TIME cycles, then IDLE; TEST: value=1 for exactly TEST_TIME cycles, then IDLE.
REQ-018 Gestures arriving during DONE, CANCEL or TEST SHALL be discarded and never queued.
REQ-019 A single 32-bit cycle counter SHALL clear to 0 on every state entry; a timed state SHALL exit on the edge where the counter equals TIME-1.
REQ-020 done_pulse SHALL be high for exactly the first cycle value=6 is presented and low at all other times.
REQ-021 If a valid gesture coincides with the SEL timeout expiry edge, the gesture SHALL win and the timeout SHALL NOT occur.
REQ-022 item SHALL hold its value across the DONE/CANCEL states and SHALL be reloaded on the next entry to SEL.
REQ-023 On any return to IDLE, value SHALL be 0 and busy SHALL be 0 in the same cycle.

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously force state=IDLE, item=0, counter=0, value=0, busy=0 and done_pulse=0.
REQ-025 Reset asserted in any state, including mid-count, SHALL abort the operation with no pending pulse or state after release.
REQ-026 The first gesture SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-027 With macro SEL_TIMEOUT_EN defined, SEL SHALL return to IDLE after SEL_TIMEOUT consecutive cycles with no accepted next/prev.
REQ-028 Without SEL_TIMEOUT_EN, SEL SHALL have no timeout and SHALL exit only via confirm or cancel; the SEL_TIMEOUT parameter SHALL then be unused.

Verification
REQ-029 The bench SHALL use DONE_TIME=8, CANCEL_TIME=6, TEST_TIME=4, SEL_TIMEOUT=10 in all scenarios below.
REQ-030 Scenario 1: next, next, next, next, next -> value goes 2,3,4,5,2 (wrap); then prev -> 5.
REQ-031 Scenario 2: next, then confirm -> done_pulse high for 1 cycle; value=6 and busy=1 for 8 cycles; then value=0 and busy=0.
REQ-032 Scenario 3: next, then cancel, then next during CANCEL -> value=7 for exactly 6 cycles, then 0; the extra next has no effect.
REQ-033 Scenario 4 (SEL_TIMEOUT_EN defined): next, then no input -> value=2 for 10 cycles, then 0; a next arriving on the 10th cycle keeps SEL with value=3.
REQ-034 Scenario 5: test from IDLE -> value=1 for 4 cycles; code 9 in IDLE -> no change.
REQ-035 Scenario 6: rst_n pulsed low mid-DONE (cycle 3) -> value=0, busy=0, done_pulse=0 immediately; a subsequent prev -> value=5.
